mul_unit: RTL and testbench

MUL_UNIT -- requirements
Module: mul_unit

---
 rtl/mul_unit.sv | 133 +++++++++++++
 tb/tb_mul_unit.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/mul_unit.sv
// ============================================================================
//  Module      : mul_unit
//  Description : Iterative signed multiplier. Operand magnitudes are latched,
//                multiplied with a fixed-length radix-2 shift-add loop and the
//                sign is re-applied to the final product.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mul_unit #(
  parameter int DATA_W = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  input  logic [DATA_W-1:0]   src1_i,
  input  logic [DATA_W-1:0]   src2_i,
  output logic                busy_o,
  output logic                done_o,
  output logic [2*DATA_W-1:0] prod_o
);

  // The iteration counter is fixed at 6 bits; the last step index depends on DATA_W.
  localparam logic [5:0] LAST_CNT = 6'(DATA_W - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t next_state;

  logic [DATA_W-1:0]   mcand;     // |src1| latched at start
  logic [DATA_W-1:0]   mplier;    // |src2|, shifted out; low half of accumulator
  logic [DATA_W:0]     acc_hi;    // upper accumulator half including carry bit
  logic                sign;
  logic [5:0]          cnt;

  logic [DATA_W-1:0]   abs1;
  logic [DATA_W-1:0]   abs2;
  logic [DATA_W-1:0]   addend;
  logic [DATA_W:0]     sum;
  logic [2*DATA_W:0]   next_acc;
  logic [2*DATA_W-1:0] mag_prod;
  logic                last_step;

  // Magnitudes: the most-negative value maps to 2^(DATA_W-1) as an unsigned number.
  assign abs1 = src1_i[DATA_W-1] ? -src1_i : src1_i;
  assign abs2 = src2_i[DATA_W-1] ? -src2_i : src2_i;

  // One shift-add step: conditionally add the multiplicand to the upper half,
  // then shift the whole {carry, upper, multiplier} accumulator right by one.
  assign addend    = mplier[0] ? mcand : '0;
  assign sum       = acc_hi + {1'b0, addend};
  assign next_acc  = {1'b0, sum, mplier[DATA_W-1:1]};
  assign mag_prod  = next_acc[2*DATA_W-1:0];
  assign last_step = (cnt == LAST_CNT);

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and status outputs; busy only in CALC, done only in DONE.
  always_comb begin
    next_state = state;
    busy_o     = 1'b0;
    done_o     = 1'b0;
    case (state)
      IDLE: begin
        if (start_i) begin
          next_state = CALC;
        end
      end
      CALC: begin
        busy_o = 1'b1;
        if (last_step) begin
          next_state = DONE;
        end
      end
      DONE: begin
        done_o     = 1'b1;
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Datapath: latch operands on accept, iterate in CALC, load the signed product on the last step.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mcand  <= '0;
      mplier <= '0;
      acc_hi <= '0;
      sign   <= 1'b0;
      cnt    <= '0;
      prod_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_i) begin
            mcand  <= abs1;
            mplier <= abs2;
            sign   <= src1_i[DATA_W-1] ^ src2_i[DATA_W-1];
            acc_hi <= '0;
            cnt    <= '0;
          end
        end
        CALC: begin
          acc_hi <= next_acc[2*DATA_W:DATA_W];
          mplier <= next_acc[DATA_W-1:0];
          cnt    <= cnt + 6'd1;
          if (last_step) begin
            prod_o <= sign ? -mag_prod : mag_prod;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mul_unit.sv
// ============================================================================
//  Module      : tb_mul_unit
//  Description : Self-checking bench for mul_unit; directed corner cases plus
//                random operands compared against a signed arithmetic model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mul_unit;

  localparam int DATA_W = 32;

  logic                clk = 1'b0;
  logic                rst;
  logic                start;
  logic [DATA_W-1:0]   src1;
  logic [DATA_W-1:0]   src2;
  logic                busy;
  logic                done;
  logic [2*DATA_W-1:0] prod;

  int n_checks = 0;
  int n_errors = 0;

  // Free-running clock.
  always #5 clk = ~clk;

  mul_unit #(.DATA_W(DATA_W)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .start_i (start),
    .src1_i  (src1),
    .src2_i  (src2),
    .busy_o  (busy),
    .done_o  (done),
    .prod_o  (prod)
  );

  // Reference: plain signed 64-bit multiplication of the two's-complement operands.
  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    longint sa;
    longint sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    return 64'(sa * sb);
  endfunction

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
    end
  endtask

  // One multiply: start pulse, 32 busy cycles with scrambled operands, done pulse, held result.
  task automatic mul_check(input logic [31:0] a, input logic [31:0] b, input bit repulse, input string tag);
    logic [63:0] exp;
    int busy_cnt;
    int early_done;
    exp        = ref_mul(a, b);
    busy_cnt   = 0;
    early_done = 0;
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b1;
    src1  = a;
    src2  = b;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 32; i++) begin
      if (busy) busy_cnt++;
      if (done) early_done++;
      src1  = $urandom;
      src2  = $urandom;
      start = 1'b0;
      if (repulse && i == 9) begin
        start = 1'b1;
        src1  = 32'd9;
        src2  = 32'd9;
      end
      @(negedge clk);
    end
    start = 1'b0;
    check_val({tag, " busy_cycles"}, 64'(busy_cnt), 64'd32);
    check_val({tag, " early_done"}, 64'(early_done), 64'd0);
    check_val({tag, " done_pulse"}, 64'(done), 64'd1);
    check_val({tag, " busy_in_done"}, 64'(busy), 64'd0);
    check_val({tag, " prod"}, prod, exp);
    @(negedge clk);
    check_val({tag, " done_cleared"}, 64'(done), 64'd0);
    check_val({tag, " prod_held"}, prod, exp);
  endtask

  // Main stimulus sequence.
  initial begin
    logic [31:0] da [6];
    logic [31:0] db [6];
    int done_seen;
    int last_c;
    int pulses;

    // Reset with start held high: the request must be discarded.
    rst   = 1'b1;
    start = 1'b1;
    src1  = 32'd3;
    src2  = 32'd5;
    repeat (3) @(negedge clk);
    check_val("reset busy", 64'(busy), 64'd0);
    check_val("reset done", 64'(done), 64'd0);
    check_val("reset prod", prod, 64'd0);

    // First multiply accepted on the very first edge after reset release.
    mul_check(32'd3, 32'd5, 1'b0, "3x5");
    check_val("3x5 literal", prod, 64'h0000_0000_0000_000F);

    mul_check(32'hFFFF_FFF9, 32'd6, 1'b0, "m7x6");
    check_val("m7x6 literal", prod, 64'hFFFF_FFFF_FFFF_FFD6);
    mul_check(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "minxm1");
    check_val("minxm1 literal", prod, 64'h0000_0000_8000_0000);
    mul_check(32'h8000_0000, 32'h8000_0000, 1'b0, "minxmin");
    check_val("minxmin literal", prod, 64'h4000_0000_0000_0000);

    // Start re-pulsed mid-calculation must be ignored.
    mul_check(32'd2, 32'd3, 1'b1, "repulse");
    check_val("repulse literal", prod, 64'd6);

    // Reset during CALC aborts the operation.
    @(negedge clk);
    start = 1'b1;
    src1  = 32'd4;
    src2  = 32'd4;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_val("abort busy", 64'(busy), 64'd0);
    check_val("abort done", 64'(done), 64'd0);
    check_val("abort prod", prod, 64'd0);
    rst       = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (done || busy) done_seen++;
      @(negedge clk);
    end
    check_val("abort no_done", 64'(done_seen), 64'd0);
    mul_check(32'd4, 32'd4, 1'b0, "4x4");
    check_val("4x4 literal", prod, 64'd16);

    // Start held high: back-to-back multiplies every 34 cycles.
    @(negedge clk);
    start  = 1'b1;
    src1   = 32'd1;
    src2   = 32'd1;
    last_c = -1;
    pulses = 0;
    for (int c = 0; c < 200 && pulses < 3; c++) begin
      @(negedge clk);
      if (done) begin
        check_val("held prod", prod, 64'd1);
        check_val("held busy_in_done", 64'(busy), 64'd0);
        if (last_c >= 0) check_val("held period", 64'(c - last_c), 64'd34);
        last_c = c;
        pulses++;
      end
    end
    check_val("held pulses", 64'(pulses), 64'd3);
    start = 1'b0;
    repeat (40) @(negedge clk);

    // Directed corners followed by random operands.
    da = '{32'd0, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'd1};
    db = '{32'd0, 32'd0, 32'h7FFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'h8000_0000};
    for (int k = 0; k < 6; k++) begin
      mul_check(da[k], db[k], 1'b0, $sformatf("corner%0d", k));
    end
    for (int k = 0; k < 30; k++) begin
      mul_check($urandom, $urandom, 1'b0, $sformatf("rand%0d", k));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
